// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - shared widths, state encoding and writeback records for mem_wb_stage
// Contents: element/vector/register widths, memory depth, ADDR_BITS derivation,
//           access state enum, scalar and vector writeback record types.
package memwb_pkg;

  localparam int ELEM_SIZE  = 8;
  localparam int VECT_SIZE  = 8;
  localparam int REGI_BITS  = 4;
  localparam int VECT_BITS  = 2;
  localparam int MEMO_LINES = 64;
  localparam int LINE_BITS  = ELEM_SIZE * VECT_SIZE;

  // Ceiling log2 of the line count; at least one bit so a 1-line memory still has an address.
  function automatic int addr_bits_f(input int lines);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << b) < lines) b = b + 1;
    end
    return (b == 0) ? 1 : b;
  endfunction

  localparam int ADDR_BITS = addr_bits_f(MEMO_LINES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef struct packed {
    logic                 en;
    logic [REGI_BITS-1:0] addr;
    logic [ELEM_SIZE-1:0] data;
  } iwb_rec_t;

  typedef struct packed {
    logic                 en;
    logic [VECT_BITS-1:0] addr;
    logic [LINE_BITS-1:0] data;
  } vwb_rec_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - request/grant/response data-memory port
// Signals: req, we, addr, wdata (stage -> memory); gnt, rvalid, rdata (memory -> stage).
// Modports: master (the stage), slave (the memory).
interface mem_wb_stage_if
  import memwb_pkg::*;
#(
  parameter int ADDR_W = ADDR_BITS,
  parameter int DATA_W = LINE_BITS
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - REQ/RESP memory handshake, address range check, halt sequencing
// Ports: clk_i, rst_i (sync, active high); accept_i/mem_read_i/mem_write_i/end_i/addr_i/wdata_i
//        describe the op transferred this cycle; mem is the memory master port;
//        idle_o, halt_o, err_o, in_range_o, rd_done_o, fwd_hit_o/fwd_data_o go to the top.
// Optional: MEMWB_STORE_FWD_EN adds a one-entry store buffer that serves matching loads.
module mem_access_fsm
  import memwb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 accept_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 end_i,
  input  logic [ELEM_SIZE-1:0] addr_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  mem_wb_stage_if.master       mem,
  output logic                 idle_o,
  output logic                 halt_o,
  output logic                 err_o,
  output logic                 in_range_o,
  output logic                 rd_done_o,
  output logic                 fwd_hit_o,
  output logic [LINE_BITS-1:0] fwd_data_o
);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 end_pend_q, end_pend_d;
  logic                 err_q, err_d;
  logic                 mem_op;
  logic                 go;

  assign in_range_o = {{(32-ELEM_SIZE){1'b0}}, addr_i} < 32'(MEMO_LINES);
  assign mem_op     = accept_i & (mem_read_i | mem_write_i);

`ifdef MEMWB_STORE_FWD_EN
  logic                 buf_valid_q, buf_valid_d;
  logic [ADDR_BITS-1:0] buf_addr_q, buf_addr_d;
  logic [LINE_BITS-1:0] buf_data_q, buf_data_d;

  // Capture the store at the moment memory accepts it, so the buffer mirrors memory contents.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (state_q == ST_REQ && we_q && mem.gnt) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = addr_q;
      buf_data_d  = wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign fwd_hit_o  = buf_valid_q & mem_read_i & in_range_o &
                      (buf_addr_q == addr_i[ADDR_BITS-1:0]);
  assign fwd_data_o = buf_data_q;
`else
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
`endif

  // Out-of-range and forwarded accesses are finished in the accept cycle and never leave IDLE.
  assign go = mem_op & in_range_o & ~(mem_read_i & fwd_hit_o);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    end_pend_d = end_pend_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_i) begin
          err_d      = mem_op & ~in_range_o;
          end_pend_d = end_i;
          if (go) begin
            addr_d  = addr_i[ADDR_BITS-1:0];
            we_d    = mem_write_i;
            wdata_d = wdata_i;
            state_d = ST_REQ;
          end else if (end_i) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_REQ: begin
        if (mem.gnt) begin
          if (we_q) state_d = end_pend_q ? ST_HALT : ST_IDLE;
          else      state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // A grant seen here is stale and deliberately ignored.
        if (mem.rvalid) state_d = end_pend_q ? ST_HALT : ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      end_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      end_pend_q <= end_pend_d;
      err_q      <= err_d;
    end
  end

  assign mem.req    = (state_q == ST_REQ);
  assign mem.we     = (state_q == ST_REQ) & we_q;
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign idle_o     = (state_q == ST_IDLE);
  assign halt_o     = (state_q == ST_HALT);
  assign err_o      = err_q;
  assign rd_done_o  = (state_q == ST_RESP) & mem.rvalid;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback stage: vector loads/stores, register and flag writeback
// Ports: clk_i, rst_i (sync, active high); valid_i/ready_o upstream handshake;
//        execute results (ialu_res_i, valu_res_i, store_data_i, alu_flags_i, control bits, rd_i, vd_i, end_i);
//        mem: data-memory master port; iwb_* scalar and vwb_* vector register write ports;
//        flags_o, err_o (out-of-range pulse), halt_o (sticky end).
// Optional: MEMWB_STORE_FWD_EN enables store-to-load forwarding inside mem_access_fsm.
module mem_wb_stage
  import memwb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [ELEM_SIZE-1:0] ialu_res_i,
  input  logic [LINE_BITS-1:0] valu_res_i,
  input  logic [LINE_BITS-1:0] store_data_i,
  input  logic [1:0]           alu_flags_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 is_vector_i,
  input  logic                 wb_en_i,
  input  logic [REGI_BITS-1:0] rd_i,
  input  logic [VECT_BITS-1:0] vd_i,
  input  logic                 end_i,
  mem_wb_stage_if.master       mem,
  output logic                 iwb_en_o,
  output logic [REGI_BITS-1:0] iwb_addr_o,
  output logic [ELEM_SIZE-1:0] iwb_data_o,
  output logic                 vwb_en_o,
  output logic [VECT_BITS-1:0] vwb_addr_o,
  output logic [LINE_BITS-1:0] vwb_data_o,
  output logic [1:0]           flags_o,
  output logic                 err_o,
  output logic                 halt_o
);

  logic                 accept;
  logic                 idle;
  logic                 in_range;
  logic                 rd_done;
  logic                 fwd_hit;
  logic [LINE_BITS-1:0] fwd_data;

  iwb_rec_t             iwb_q, iwb_d;
  vwb_rec_t             vwb_q, vwb_d;
  logic [1:0]           flags_q, flags_d;
  logic [VECT_BITS-1:0] ld_vd_q, ld_vd_d;

  assign ready_o = idle;
  assign accept  = valid_i & ready_o;

  mem_access_fsm u_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .accept_i    (accept),
    .mem_read_i  (mem_read_i),
    .mem_write_i (mem_write_i),
    .end_i       (end_i),
    .addr_i      (ialu_res_i),
    .wdata_i     (store_data_i),
    .mem         (mem),
    .idle_o      (idle),
    .halt_o      (halt_o),
    .err_o       (err_o),
    .in_range_o  (in_range),
    .rd_done_o   (rd_done),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data)
  );

  // Writeback records default to zero so each enable is a one-cycle pulse.
  // rd_done only occurs in RESP and accept only in IDLE, so the vector port is never double-booked.
  always_comb begin
    iwb_d   = '0;
    vwb_d   = '0;
    flags_d = flags_q;
    ld_vd_d = ld_vd_q;
    if (rd_done) begin
      vwb_d.en   = 1'b1;
      vwb_d.addr = ld_vd_q;
      vwb_d.data = mem.rdata;
    end else if (accept) begin
      flags_d = alu_flags_i;
      if (mem_read_i) begin
        ld_vd_d = vd_i;
        if (!in_range) begin
          vwb_d.en   = 1'b1;
          vwb_d.addr = vd_i;
        end else if (fwd_hit) begin
          vwb_d.en   = 1'b1;
          vwb_d.addr = vd_i;
          vwb_d.data = fwd_data;
        end
      end else if (!mem_write_i && wb_en_i) begin
        if (is_vector_i) begin
          vwb_d.en   = 1'b1;
          vwb_d.addr = vd_i;
          vwb_d.data = valu_res_i;
        end else begin
          iwb_d.en   = 1'b1;
          iwb_d.addr = rd_i;
          iwb_d.data = ialu_res_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iwb_q   <= '0;
      vwb_q   <= '0;
      flags_q <= '0;
      ld_vd_q <= '0;
    end else begin
      iwb_q   <= iwb_d;
      vwb_q   <= vwb_d;
      flags_q <= flags_d;
      ld_vd_q <= ld_vd_d;
    end
  end

  assign iwb_en_o   = iwb_q.en;
  assign iwb_addr_o = iwb_q.addr;
  assign iwb_data_o = iwb_q.data;
  assign vwb_en_o   = vwb_q.en;
  assign vwb_addr_o = vwb_q.addr;
  assign vwb_data_o = vwb_q.data;
  assign flags_o    = flags_q;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/writeback stage that consumes the execute stage's results: scalar ALU result, vector ALU result, ALU flags and memory-control flags.
- Performs vector-line loads and stores through a request/grant/response data-memory port.
- Drives the write ports of the scalar and vector register files and the flag register.
- Stalls the upstream execute stage while a memory access is outstanding, and halts on the end flag.

Parameters:
ELEM_SIZE, 8, element width in bits
VECT_SIZE, 8, elements per vector
REGI_BITS, 4, scalar register index width
VECT_BITS, 2, vector register index width
MEMO_LINES, 64, data memory depth in vector lines
ADDR_BITS, 6, memory address width, equal to clog2(MEMO_LINES)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  execute result valid
ready_o  out  1  stage can accept; transfer occurs when valid_i && ready_o
ialu_res_i  in  ELEM_SIZE  scalar result; also the memory address
valu_res_i  in  ELEM_SIZE*VECT_SIZE  vector ALU/swap result
store_data_i  in  ELEM_SIZE*VECT_SIZE  vector store data
alu_flags_i  in  2  ALU flags
mem_read_i, mem_write_i  in  1 each  load / store request; never both set
is_vector_i  in  1  result targets the vector register file
wb_en_i  in  1  register writeback required
rd_i  in  REGI_BITS  scalar destination register
vd_i  in  VECT_BITS  vector destination register
end_i  in  1  program end
mem_req_o, mem_we_o  out  1 each  memory request; write enable
mem_addr_o  out  ADDR_BITS  memory line address
mem_wdata_o  out  ELEM_SIZE*VECT_SIZE  memory write data
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  ELEM_SIZE*VECT_SIZE  read data
iwb_en_o, iwb_addr_o[REGI_BITS], iwb_data_o[ELEM_SIZE]  out  scalar register write port
vwb_en_o, vwb_addr_o[VECT_BITS], vwb_data_o[ELEM_SIZE*VECT_SIZE]  out  vector register write port
flags_o  out  2  registered flags
err_o  out  1  one-cycle pulse on an out-of-range address
halt_o  out  1  sticky end indication

Behaviour:
- Reset values:
  - all outputs 0, except ready_o = 1
  - state IDLE
- States:
  - IDLE: ready_o = 1.
  - REQ: mem_req_o held high with address, we and wdata stable until mem_gnt_i.
  - RESP: waits for mem_rvalid_i.
  - HALT: ready_o = 0, halt_o = 1 until reset.
- Non-memory op accepted in cycle N:
  - In cycle N+1, exactly one of iwb_en_o (is_vector_i = 0) or vwb_en_o (is_vector_i = 1) pulses, provided wb_en_i = 1.
  - Writeback uses registered data and address.
  - flags_o updates at N+1.
  - Stage stays in IDLE, so back-to-back throughput is 1 op/cycle.
- Memory op accepted:
  - mem_addr_o = ialu_res_i[ADDR_BITS-1:0].
  - If ialu_res_i >= MEMO_LINES:
    - no request is issued;
    - err_o pulses at N+1;
    - a load writes back a zero vector at N+1;
    - state stays IDLE.
  - Otherwise go to REQ at N+1 with ready_o = 0.
  - Store: on mem_gnt_i return to IDLE; no writeback.
  - Load: on mem_gnt_i go to RESP. When mem_rvalid_i arrives in cycle R, vwb_en_o pulses at R+1 with data = mem_rdata_i and address = the registered vd_i, and the stage returns to IDLE.
  - Grant and rvalid in the same cycle are legal only in RESP; a grant while in RESP is ignored.
  - mem_rvalid_i outside RESP is ignored.
- end_i accepted: complete any writeback for that op, then enter HALT. Inputs are ignored in HALT.
- Reset mid-access:
  - next edge clears mem_req_o and returns to IDLE;
  - late mem_rvalid_i is discarded;
  - no writeback.
- Writeback enables are single-cycle pulses and never asserted in the same cycle as each other.

Optional Feature:
- MEMWB_STORE_FWD_EN defined:
  - A one-entry store buffer holds {valid, addr, data} of the last granted store.
  - A load to a matching address issues no memory request; vwb_en_o pulses at N+1 with the buffered data, and the stage stays IDLE.
  - The buffer is invalidated on reset.
- MEMWB_STORE_FWD_EN undefined: every load goes to memory; no buffer logic.

Decomposition:
- Package memwb_pkg holds:
  - state enum (IDLE, REQ, RESP, HALT);
  - ADDR_BITS derivation function;
  - writeback record typedef {en, addr, data}.
- Natural sub-module: mem_access_fsm, which owns the REQ/RESP handshake and address range check. The top level owns the writeback registers, flags register and halt logic.

Test Plan:
- Scalar op: valid_i = 1, ialu_res_i = 8'h5A, rd_i = 3, wb_en_i = 1, alu_flags_i = 2'b10 -> next cycle iwb_en_o = 1, iwb_addr_o = 3, iwb_data_o = 8'h5A, flags_o = 2'b10.
- Store then load, addr 12, data 64'h0123456789ABCDEF, grant after 2 cycles, rvalid 3 cycles later -> mem_we_o = 1 then 0; vwb_data_o = 64'h0123456789ABCDEF one cycle after rvalid; ready_o low throughout each access.
- Load with ialu_res_i = 8'd70 -> no mem_req_o; err_o pulse; vwb_data_o = 0.
- rst_i asserted while in RESP, rvalid 1 cycle later -> no vwb_en_o; ready_o = 1 after reset.
- end_i with scalar writeback -> iwb pulse, then halt_o = 1 and ready_o = 0 permanently; later valid_i is ignored.
- With MEMWB_STORE_FWD_EN: store addr 5, then load addr 5 -> mem_req_o stays low for the load; vwb_en_o at N+1 with the stored data.
